sd_dma_wbuf: RTL and testbench
==============================

// Module: sd_dma_wbuf
// PURPOSE
// Posted-write buffer and read sequencer between the SD controller's DMA master
// (Wishbone-style: strobe held until one-cycle ack) and the system Avalon-MM fabric.
// Write bursts from the SD card go into a FIFO and drain to memory as the fabric
// allows. DMA reads (card writes) are ordered behind all posted writes and issued
// as single pipelined Avalon reads.
// PARAMETERS
// FIFO_DEPTH  8   write FIFO entries; power of two, >=2
// ADDR_W      32  byte address width
// DATA_W      32  data width; word transfers only, all byte lanes enabled
// PORTS
// clk              in   1       system clock
// reset            in   1       asynchronous, active-high reset
// s_address        in   ADDR_W  upstream byte address
// s_read           in   1       upstream read request, held until acked
// s_write          in   1       upstream write request, held until acked
// s_writedata      in   DATA_W  upstream write data
// s_readdata       out  DATA_W  read data; valid in the cycle s_waitrequest_n=1
// s_waitrequest_n  out  1       one-cycle ack, active-high
// m_address        out  ADDR_W  downstream word-aligned address, bits[1:0]=0
// m_read           out  1       downstream read, held while m_waitrequest=1
// m_write          out  1       downstream write, held while m_waitrequest=1
// m_writedata      out  DATA_W  downstream write data
// m_waitrequest    in   1       fabric stall, active-high
// m_readdata       in   DATA_W  fabric read data
// m_readdatavalid  in   1       fabric read data valid
// fifo_level       out  log2(FIFO_DEPTH)+1  current write FIFO occupancy
// idle             out  1       FIFO empty, FSM in IDLE, no downstream op active
// BEHAVIOUR
// Reset: all outputs 0 except idle=1; FIFO pointers, level and FSM cleared.
// In-flight downstream ops are abandoned; readdatavalid seen in IDLE is ignored.
// Write accept: s_waitrequest_n = s_write & ~full & (state==IDLE), combinational.
//  - On that edge, {address[ADDR_W-1:2],writedata} is pushed. One ack per request.
//  - The upstream drops the strobe on the ack edge.
// Write drain: when FIFO not empty and state!=RD_CMD/RD_DATA, head drives m_write.
//  - Pop occurs on the edge where m_write=1 and m_waitrequest=0.
//  - A push when full is impossible, because no ack is given.
//  - Push and pop in the same cycle leave fifo_level unchanged.
//  - Pointers wrap modulo FIFO_DEPTH.
// Both s_read and s_write asserted is a protocol error; the write wins and the
// read is ignored that cycle.
// Read FSM:
//  IDLE     -> DRAIN when s_read & ~s_write.
//  DRAIN    -> RD_CMD when FIFO empty and no m_write pending; enforces RAW ordering.
//  RD_CMD   -> m_read=1 with the latched address; RD_DATA on the edge m_waitrequest=0.
//  RD_DATA  -> capture m_readdata on m_readdatavalid, then RD_ACK.
//  RD_ACK   -> s_waitrequest_n=1 for exactly one cycle with the captured data; then IDLE.
//  Minimum read latency s_read->ack is 3 cycles, with FIFO empty, zero wait and
//  readdatavalid the cycle after the command.
//  No write acks while state!=IDLE; the FIFO still drains during DRAIN.
//  m_read and m_write are never asserted in the same cycle.
// m_address, m_writedata and m_read/m_write stay stable while m_waitrequest=1.
// TESTING
// - Write posting: 8 back-to-back writes to 0x1000..0x101C with m_waitrequest=1
//   -> 8 acks, fifo_level=8, 9th write stalls; release stall -> 8 in-order m_writes,
//   then 9th acked.
// - Read after write: write 0xA5A5A5A5 to 0x2000, then read 0x2000 with fabric
//   stalled 4 cycles -> m_read issued only after that m_write completes; s_readdata
//   = model value.
// - Read timing: FIFO empty, zero-wait fabric, readdatavalid +1 cycle
//   -> ack exactly 3 cycles after s_read rises, one cycle wide.
// - Address alignment: write to 0x3003 -> m_address=0x3000.
// - Wrap/simultaneous: 20 writes with random stall, push+pop same cycle
//   -> level tracks and the data order is preserved across pointer wrap.
// - Reset mid-read: assert reset in RD_DATA, then send a late readdatavalid
//   -> all outputs 0, idle=1, no spurious ack.

Source files
------------

// File: rtl/sd_dma_wbuf.sv
// Posted-write FIFO plus ordered read sequencer bridging a Wishbone-style DMA master
// onto an Avalon-MM fabric. Reads wait behind every posted write.
module sd_dma_wbuf #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             s_address,
  input  logic                          s_read,
  input  logic                          s_write,
  input  logic [DATA_W-1:0]             s_writedata,
  output logic [DATA_W-1:0]             s_readdata,
  output logic                          s_waitrequest_n,
  output logic [ADDR_W-1:0]             m_address,
  output logic                          m_read,
  output logic                          m_write,
  output logic [DATA_W-1:0]             m_writedata,
  input  logic                          m_waitrequest,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_readdatavalid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam int ENT_W = WA_W + DATA_W;

  typedef enum logic [2:0] {IDLE, DRAIN, RD_CMD, RD_DATA, RD_ACK} state_t;

  state_t              state_reg;
  logic [WA_W-1:0]     rd_addr_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [ENT_W-1:0]    head;
  logic                full, empty, push, pop, drain_ok;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^s_address[1:0];

  assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_reg == '0);
  assign push     = s_write && !full && (state_reg == IDLE);
  assign drain_ok = (state_reg != RD_CMD) && (state_reg != RD_DATA);
  assign head     = mem[rd_ptr_reg];

  assign m_write  = !empty && drain_ok;
  assign m_read   = (state_reg == RD_CMD);
  assign pop      = m_write && !m_waitrequest;

  // Idle buses are driven to zero so nothing stale leaks out of the RAM.
  assign m_address   = m_read  ? {rd_addr_reg, 2'b00} :
                       m_write ? {head[ENT_W-1 -: WA_W], 2'b00} : '0;
  assign m_writedata = m_write ? head[DATA_W-1:0] : '0;

  assign s_waitrequest_n = push || (state_reg == RD_ACK);
  assign s_readdata      = rd_data_reg;
  assign fifo_level      = level_reg;
  assign idle            = empty && (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {s_address[ADDR_W-1:2], s_writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // DRAIN holds the read back until every posted write has left the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (s_read && !s_write) begin
          rd_addr_reg <= s_address[ADDR_W-1:2];
          state_reg   <= DRAIN;
        end
        DRAIN:   if (empty) state_reg <= RD_CMD;
        RD_CMD:  if (!m_waitrequest) state_reg <= RD_DATA;
        RD_DATA: if (m_readdatavalid) begin
          rd_data_reg <= m_readdata;
          state_reg   <= RD_ACK;
        end
        RD_ACK:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dma_wbuf.sv
// Directed bench for sd_dma_wbuf: write table, posting/stall, RAW ordering,
// read latency, FIFO wrap with random stall, and reset in the middle of a read.
module tb_sd_dma_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_waitrequest_n;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata = 32'h0;
  logic        m_readdatavalid = 1'b0;
  logic [3:0]  fifo_level;
  logic        idle;

  sd_dma_wbuf #(.FIFO_DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_waitrequest_n(s_waitrequest_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .fifo_level(fifo_level), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
  } wvec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wrec_t;

  int n_checks = 0;
  int n_fail   = 0;

  wrec_t       wr_log[$];
  logic [31:0] mem_model [logic [31:0]];
  logic        auto_resp  = 1'b1;
  logic        inject_rdv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fabric side: log accepted writes into the memory model
  always @(posedge clk) begin
    if (!rst && m_write && !m_waitrequest) begin
      wr_log.push_back('{addr: m_address, data: m_writedata});
      mem_model[m_address] = m_writedata;
      $display("fabric write addr=0x%08h data=0x%08h", m_address, m_writedata);
    end
  end

  // Fabric side: readdatavalid one cycle after an accepted read command
  always @(posedge clk) begin
    logic        rv;
    logic [31:0] rd;
    rv = auto_resp && !rst && m_read && !m_waitrequest;
    rd = (rv && mem_model.exists(m_address)) ? mem_model[m_address] : 32'h0;
    if (rv) $display("fabric read  addr=0x%08h data=0x%08h", m_address, rd);
    if (inject_rdv) begin
      rv = 1'b1;
      rd = 32'hBADBAD00;
    end
    #1;
    m_readdatavalid = rv;
    m_readdata      = rd;
  end

  wvec_t vecs[4];

  initial begin
    int acks9, cyc, lvl, sent, both;
    logic seen_rd, done, psh, pp;

    vecs[0] = '{addr: 32'h0000_1000, data: 32'h1111_1111, exp_addr: 32'h0000_1000};
    vecs[1] = '{addr: 32'h0000_3003, data: 32'hCAFE_F00D, exp_addr: 32'h0000_3000};
    vecs[2] = '{addr: 32'hFFFF_FFFE, data: 32'h0000_0000, exp_addr: 32'hFFFF_FFFC};
    vecs[3] = '{addr: 32'h0000_0005, data: 32'hFFFF_FFFF, exp_addr: 32'h0000_0004};

    rst = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0;
    s_writedata = '0; m_waitrequest = 1'b0;

    // ---- reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ack", s_waitrequest_n, 0);
    chk("rst_mread", m_read, 0);
    chk("rst_mwrite", m_write, 0);
    chk("rst_maddr", m_address, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_idle", idle, 1);
    chk("rst_rdata", s_readdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // ---- table: single zero-wait writes incl. address alignment
    for (int i = 0; i < 4; i++) begin
      wr_log.delete();
      s_address = vecs[i].addr; s_writedata = vecs[i].data; s_write = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), s_waitrequest_n, 1);
      tick();
      s_write = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_mwrite", i), m_write, 1);
      chk($sformatf("vec%0d_maddr", i), m_address, vecs[i].exp_addr);
      chk($sformatf("vec%0d_mdata", i), m_writedata, vecs[i].data);
      chk($sformatf("vec%0d_level", i), fifo_level, 1);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), fifo_level, 0);
      chk($sformatf("vec%0d_idle", i), idle, 1);
      chk($sformatf("vec%0d_log", i), wr_log.size(), 1);
      tick();
    end

    // ---- write posting with stalled fabric
    wr_log.delete();
    m_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_address = 32'h1000 + 32'(4 * i); s_writedata = 32'hD000_0000 + 32'(i);
      s_write = 1'b1;
      @(negedge clk);
      chk($sformatf("post%0d_ack", i), s_waitrequest_n, 1);
      tick();
    end
    s_address = 32'h1020; s_writedata = 32'hD000_0008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post9_stall", s_waitrequest_n, 0);
      chk("post_full_level", fifo_level, 8);
      chk("post_hold_addr", m_address, 32'h1000);
      tick();
    end
    m_waitrequest = 1'b0;
    acks9 = 0;
    for (cyc = 0; cyc < 40 && wr_log.size() < 9; cyc++) begin
      @(negedge clk);
      done = s_write && s_waitrequest_n;
      if (done) acks9++;
      tick();
      if (done) s_write = 1'b0;
    end
    chk("post_timeout", cyc < 40, 1);
    chk("post9_acks", acks9, 1);
    chk("post_log_size", wr_log.size(), 9);
    for (int i = 0; i < 9 && i < wr_log.size(); i++) begin
      chk($sformatf("post_order_a%0d", i), wr_log[i].addr, 32'h1000 + 32'(4 * i));
      chk($sformatf("post_order_d%0d", i), wr_log[i].data, 32'hD000_0000 + 32'(i));
    end
    tick();

    // ---- read after write, fabric stalled 4 cycles
    wr_log.delete();
    m_waitrequest = 1'b1;
    s_address = 32'h2000; s_writedata = 32'hA5A5A5A5; s_write = 1'b1;
    @(negedge clk);
    chk("raw_wr_ack", s_waitrequest_n, 1);
    tick();
    s_write = 1'b0; s_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("raw_no_mread", m_read, 0);
      chk("raw_mwrite_held", m_write, 1);
      tick();
    end
    m_waitrequest = 1'b0;
    seen_rd = 1'b0; done = 1'b0;
    for (cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (m_read && m_write) chk("raw_both_strobes", 1, 0);
      if (m_read && !seen_rd) begin
        seen_rd = 1'b1;
        chk("raw_order", wr_log.size(), 1);
        chk("raw_rd_addr", m_address, 32'h2000);
      end
      if (s_waitrequest_n) begin
        done = 1'b1;
        chk("raw_rdata", s_readdata, 32'hA5A5A5A5);
      end
      tick();
    end
    s_read = 1'b0;
    chk("raw_done", done, 1);
    tick();

    // ---- read timing: ack exactly 3 cycles after s_read is first sampled
    mem_model[32'h4000] = 32'h1234_5678;
    s_address = 32'h4000; s_read = 1'b1;
    tick();
    @(negedge clk); chk("rt_c1_ack", s_waitrequest_n, 0);
    tick();
    @(negedge clk); chk("rt_c2_ack", s_waitrequest_n, 0); chk("rt_c2_mread", m_read, 1);
    tick();
    @(negedge clk); chk("rt_c3_ack", s_waitrequest_n, 0); chk("rt_c3_mread", m_read, 0);
    tick();
    @(negedge clk); chk("rt_c4_ack", s_waitrequest_n, 1);
    chk("rt_rdata", s_readdata, 32'h1234_5678);
    tick();
    s_read = 1'b0;
    @(negedge clk); chk("rt_c5_ack", s_waitrequest_n, 0); chk("rt_c5_idle", idle, 1);
    tick();

    // ---- wrap with random stall, push and pop in the same cycle
    wr_log.delete();
    lvl = 0; sent = 0; both = 0;
    s_address = 32'h5000; s_writedata = 32'h6000_0000; s_write = 1'b1;
    for (cyc = 0; cyc < 400 && (sent < 20 || lvl != 0); cyc++) begin
      @(negedge clk);
      psh = s_write && s_waitrequest_n;
      pp  = m_write && !m_waitrequest;
      chk("wrap_level", fifo_level, lvl);
      lvl = lvl + int'(psh) - int'(pp);
      if (psh && pp) both++;
      tick();
      if (psh) begin
        sent++;
        if (sent < 20) begin
          s_address   = 32'h5000 + 32'(4 * sent);
          s_writedata = 32'h6000_0000 + 32'(sent * 17);
        end else s_write = 1'b0;
      end
      m_waitrequest = (sent < 20) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
    $display("wrap run: %0d cycles, %0d simultaneous push/pop", cyc, both);
    chk("wrap_timeout", cyc < 400, 1);
    chk("wrap_log_size", wr_log.size(), 20);
    for (int i = 0; i < 20 && i < wr_log.size(); i++) begin
      chk($sformatf("wrap_a%0d", i), wr_log[i].addr, 32'h5000 + 32'(4 * i));
      chk($sformatf("wrap_d%0d", i), wr_log[i].data, 32'h6000_0000 + 32'(i * 17));
    end
    m_waitrequest = 1'b0;
    tick();

    // ---- reset while waiting for read data, then a late readdatavalid
    auto_resp = 1'b0;
    s_address = 32'h7000; s_read = 1'b1;
    tick(); tick();
    @(negedge clk); chk("mr_cmd", m_read, 1);
    tick();
    @(negedge clk); chk("mr_in_data", idle, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mr_rst_ack", s_waitrequest_n, 0);
    chk("mr_rst_mread", m_read, 0);
    chk("mr_rst_mwrite", m_write, 0);
    chk("mr_rst_maddr", m_address, 0);
    chk("mr_rst_rdata", s_readdata, 0);
    chk("mr_rst_idle", idle, 1);
    s_read = 1'b0;
    tick();
    rst = 1'b0;
    inject_rdv = 1'b1;
    tick();
    inject_rdv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_ack", s_waitrequest_n, 0);
      chk("mr_idle", idle, 1);
      chk("mr_rdata", s_readdata, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
